disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
- Seven-segment display scanner downstream of the core's debug display output. It consumes the 32-bit word selected by disp_sel, the core's disp_data, and drives an 8-digit multiplexed, common-anode hex display.
- It snapshots the word once per scan frame, so digits never tear mid-frame. It also provides leading-zero blanking, a freeze (hold) control and a frame-boundary pulse.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit; legal range 2..65535.
- DIV_W, 16, width of the refresh divider counter; must satisfy 2^DIV_W > REFRESH_DIV.

Ports:
- clk  input  1  system clock, same clock as the core.
- reset  input  1  asynchronous, active-low reset.
- disp_data  input  32  word to display; the core's disp_data.
- hold  input  1  1 = freeze the current snapshot; scanning continues.
- blank_lz  input  1  1 = blank leading-zero digits.
- an  output  8  digit enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse after each frame boundary.

Behaviour:
- Reset (reset=0, asynchronous):
  - div=0, digit=0, snap=32'h0, prime=1.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Divider: div counts 0..REFRESH_DIV-1. The terminal count tc is div==REFRESH_DIV-1. On tc, div returns to 0 and digit advances by 1, wrapping from 7 to 0.
- Frame boundary fb = tc && digit==7.
- Snapshot load:
  - snap<=disp_data when (prime) or (fb && !hold).
  - prime clears on the first clock edge after reset release, so the first frame shows live data.
  - hold=1 suppresses only the fb-triggered load. A prime load occurs regardless of hold.
- Nibble select: digit i shows snap[4i+3:4i].
- Hex encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Blanking: with blank_lz=1, digit i (i>=1) is blanked when snap[31:4i]==0. Digit 0 is never blanked. Blanking is evaluated on snap, not on disp_data.
- Registered outputs: an, seg and dp are registered from the current digit and snap, so they lag a digit change by exactly 1 cycle.
  - an = ~(1<<digit) when the digit is not blanked; 8'hFF when blanked.
  - seg = encoding of the selected nibble when not blanked; 7'h7F when blanked.
  - dp = 0 only when digit==0 and hold==1 (freeze indicator); otherwise 1.
- Ghosting: an is never more than one bit low in any cycle.
- frame_tick is registered. It is 1 in the cycle after each fb edge, independent of hold, and never 1 for two consecutive cycles.
- disp_data changes are visible only at the next snapshot load. Maximum latency is 8*REFRESH_DIV+1 cycles.
- Reset asserted mid-frame returns all state to reset values immediately. After release, scanning restarts at digit 0 with a prime load.
- hold toggling mid-frame has no effect on the current frame's contents.

Test Plan:
- REFRESH_DIV=4, disp_data=32'h12345678, hold=0, blank_lz=0, release reset:
  - an walks FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles.
  - seg sequence is 0000000(8), 1111000(7), 0000010(6), 0010010(5), 0011001(4), 0110000(3), 0100100(2), 1111001(1).
  - frame_tick pulses every 32 cycles.
- Tearing: change disp_data to 32'hDEADBEEF while digit 3 is lit.
  - The remaining digits of that frame still show 1234.
  - The next frame shows F,E,E,b,d,A,E,d on digits 0..7.
- Hold: set hold=1 after the first frame, then change disp_data to 32'h0.
  - Display stays 12345678 across 3 frames.
  - dp=0 whenever an=8'hFE.
  - frame_tick still pulses every 32 cycles.
  - Deassert hold: the new value appears at the next boundary.
- Blanking: disp_data=32'h00000A05, blank_lz=1.
  - Only digits 0..2 are lit (5,0,A).
  - an=8'hFF during the slots for digits 3..7.
  - disp_data=0 lights only digit 0 with seg=1000000.
- Reset mid-scan: assert reset during digit 5.
  - Outputs go to FF/7F/1/0 asynchronously, without waiting for a clock.
  - After release, digit 0 is lit first with freshly primed data.
- REFRESH_DIV=2 boundary:
  - Each digit is lit 2 cycles and the frame is 16 cycles.
  - an never has two zero bits at once.

Source files
------------

// File: rtl/disp_scan.sv
// Eight-digit multiplexed hex scanner for a common-anode seven-segment display.
// Snapshots the input word once per frame and drives registered, active-low digit/segment lines.
module disp_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic        hold,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      snap_q, snap_d;
    logic             prime_q;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q;

    logic             tc;
    logic             fb;
    logic [3:0]       nibble;
    logic [31:0]      upper;
    logic             blanked;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tc      = (div_q == DIV_LAST);
        fb      = tc && (digit_q == 3'd7);
        nibble  = snap_q[{digit_q, 2'b00} +: 4];
        // A digit is a leading zero when it and everything above it in the snapshot is zero.
        upper   = snap_q >> {digit_q, 2'b00};
        blanked = blank_lz && (digit_q != 3'd0) && (upper == 32'h0);

        div_d   = tc ? '0 : div_q + 1'b1;
        digit_d = tc ? digit_q + 3'd1 : digit_q;
        snap_d  = (prime_q || (fb && !hold)) ? disp_data : snap_q;

        an_d    = blanked ? 8'hFF : ~(8'd1 << digit_q);
        seg_d   = blanked ? 7'h7F : hex7(nibble);
        dp_d    = !((digit_q == 3'd0) && hold);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            digit_q      <= 3'd0;
            snap_q       <= 32'h0;
            prime_q      <= 1'b1;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            digit_q      <= digit_d;
            snap_q       <= snap_d;
            prime_q      <= 1'b0;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= fb;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed self-checking bench for disp_scan: scan order, tearing, hold, blanking, reset, short divider.
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] disp_data;
    logic        hold;
    logic        blank_lz;
    logic [7:0]  an,  an2;
    logic [6:0]  seg, seg2;
    logic        dp,  dp2;
    logic        frame_tick, frame_tick2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    disp_scan #(.REFRESH_DIV(4), .DIV_W(16)) u_dut (
        .clk(clk), .reset(reset), .disp_data(disp_data), .hold(hold), .blank_lz(blank_lz),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    disp_scan #(.REFRESH_DIV(2), .DIV_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .disp_data(disp_data), .hold(hold), .blank_lz(blank_lz),
        .an(an2), .seg(seg2), .dp(dp2), .frame_tick(frame_tick2)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] tab [16];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tab[n];
    endfunction

    function automatic logic is_blank(input logic [31:0] w, input int d, input logic blank);
        logic [31:0] up;
        up = w >> (4 * d);
        return blank && (d != 0) && (up == 32'h0);
    endfunction

    function automatic logic [7:0] exp_an(input logic [31:0] w, input int d, input logic blank);
        logic [7:0] one_hot;
        one_hot = 8'd1 << d;
        return is_blank(w, d, blank) ? 8'hFF : ~one_hot;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [31:0] w, input int d, input logic blank);
        logic [31:0] sh;
        sh = w >> (4 * d);
        return is_blank(w, d, blank) ? 7'h7F : hex7(sh[3:0]);
    endfunction

    // Observation k is taken 1 time unit after the k-th rising edge following reset release.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; blank_lz = 1'b0; disp_data = 32'h12345678;
        #1;
        reset = 1'b0;
        #2;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        checks++; if (an2 !== 8'hFF || seg2 !== 7'h7F) begin errors++; $display("FAIL reset_dut2 got an=%h seg=%h exp ff/7f", an2, seg2); end
    endtask

    task automatic test_scan();
        logic [31:0] w;
        int d;
        w = 32'h12345678;
        hold = 1'b0; blank_lz = 1'b0; disp_data = w;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            step();
            d = ((k - 1) / 4) % 8;
            checks++; if (an !== exp_an(w, d, 1'b0)) begin errors++; $display("FAIL scan_an k=%0d got %h exp %h", k, an, exp_an(w, d, 1'b0)); end
            // The first cycle still reflects the pre-prime snapshot, so its segments are not checked.
            if (k > 1) begin
                checks++; if (seg !== exp_seg(w, d, 1'b0)) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg, exp_seg(w, d, 1'b0)); end
            end
            checks++; if (dp !== 1'b1) begin errors++; $display("FAIL scan_dp k=%0d got %b exp 1", k, dp); end
            checks++; if (frame_tick !== (k % 32 == 0)) begin errors++; $display("FAIL scan_tick k=%0d got %b exp %b", k, frame_tick, (k % 32 == 0)); end
            checks++; if ($countones(~an) > 1) begin errors++; $display("FAIL scan_ghost k=%0d got an=%h exp at most one low bit", k, an); end
        end
    endtask

    task automatic test_tearing();
        logic [31:0] w;
        int d;
        hold = 1'b0; blank_lz = 1'b0; disp_data = 32'h12345678;
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            step();
            d = ((k - 1) / 4) % 8;
            w = (k <= 32) ? 32'h12345678 : 32'hDEADBEEF;
            checks++; if (an !== exp_an(w, d, 1'b0)) begin errors++; $display("FAIL tear_an k=%0d got %h exp %h", k, an, exp_an(w, d, 1'b0)); end
            if (k > 1) begin
                checks++; if (seg !== exp_seg(w, d, 1'b0)) begin errors++; $display("FAIL tear_seg k=%0d got %b exp %b", k, seg, exp_seg(w, d, 1'b0)); end
            end
            if (k == 14) disp_data = 32'hDEADBEEF;
        end
    endtask

    task automatic test_hold();
        logic [31:0] w;
        logic h;
        int d;
        hold = 1'b0; blank_lz = 1'b0; disp_data = 32'h12345678;
        do_reset();
        for (int k = 1; k <= 192; k++) begin
            h = hold;
            step();
            d = ((k - 1) / 4) % 8;
            w = (k <= 160) ? 32'h12345678 : 32'h0;
            checks++; if (an !== exp_an(w, d, 1'b0)) begin errors++; $display("FAIL hold_an k=%0d got %h exp %h", k, an, exp_an(w, d, 1'b0)); end
            if (k > 1) begin
                checks++; if (seg !== exp_seg(w, d, 1'b0)) begin errors++; $display("FAIL hold_seg k=%0d got %b exp %b", k, seg, exp_seg(w, d, 1'b0)); end
            end
            checks++; if (dp !== !(h && d == 0)) begin errors++; $display("FAIL hold_dp k=%0d got %b exp %b", k, dp, !(h && d == 0)); end
            checks++; if (frame_tick !== (k % 32 == 0)) begin errors++; $display("FAIL hold_tick k=%0d got %b exp %b", k, frame_tick, (k % 32 == 0)); end
            if (k == 33) begin hold = 1'b1; disp_data = 32'h0; end
            if (k == 130) hold = 1'b0;
        end
    endtask

    task automatic test_blank();
        logic [31:0] w;
        int d;
        hold = 1'b0; blank_lz = 1'b1; disp_data = 32'h00000A05;
        do_reset();
        for (int k = 1; k <= 96; k++) begin
            step();
            d = ((k - 1) / 4) % 8;
            w = (k <= 64) ? 32'h00000A05 : 32'h0;
            checks++; if (an !== exp_an(w, d, 1'b1)) begin errors++; $display("FAIL blank_an k=%0d got %h exp %h", k, an, exp_an(w, d, 1'b1)); end
            if (k > 1) begin
                checks++; if (seg !== exp_seg(w, d, 1'b1)) begin errors++; $display("FAIL blank_seg k=%0d got %b exp %b", k, seg, exp_seg(w, d, 1'b1)); end
            end
            if (k == 40) disp_data = 32'h0;
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        int d;
        hold = 1'b0; blank_lz = 1'b0; disp_data = 32'h12345678;
        do_reset();
        for (int k = 1; k <= 22; k++) step();
        checks++; if (an !== 8'hDF) begin errors++; $display("FAIL midrst_pre_an got %h exp df", an); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midrst_an got %h exp ff", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg got %h exp 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL midrst_dp got %b exp 1", dp); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b exp 0", frame_tick); end
        w = 32'hCAFE0123;
        disp_data = w;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            d = ((k - 1) / 4) % 8;
            checks++; if (an !== exp_an(w, d, 1'b0)) begin errors++; $display("FAIL midrst_scan_an k=%0d got %h exp %h", k, an, exp_an(w, d, 1'b0)); end
            if (k > 1) begin
                checks++; if (seg !== exp_seg(w, d, 1'b0)) begin errors++; $display("FAIL midrst_scan_seg k=%0d got %b exp %b", k, seg, exp_seg(w, d, 1'b0)); end
            end
            checks++; if (frame_tick !== (k == 32)) begin errors++; $display("FAIL midrst_scan_tick k=%0d got %b exp %b", k, frame_tick, (k == 32)); end
        end
    endtask

    task automatic test_div2();
        logic [31:0] w;
        int d;
        w = 32'h12345678;
        hold = 1'b0; blank_lz = 1'b0; disp_data = w;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            d = ((k - 1) / 2) % 8;
            checks++; if (an2 !== exp_an(w, d, 1'b0)) begin errors++; $display("FAIL div2_an k=%0d got %h exp %h", k, an2, exp_an(w, d, 1'b0)); end
            if (k > 1) begin
                checks++; if (seg2 !== exp_seg(w, d, 1'b0)) begin errors++; $display("FAIL div2_seg k=%0d got %b exp %b", k, seg2, exp_seg(w, d, 1'b0)); end
            end
            checks++; if (frame_tick2 !== (k % 16 == 0)) begin errors++; $display("FAIL div2_tick k=%0d got %b exp %b", k, frame_tick2, (k % 16 == 0)); end
            checks++; if ($countones(~an2) > 1) begin errors++; $display("FAIL div2_ghost k=%0d got an=%h exp at most one low bit", k, an2); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_hold();
        test_blank();
        test_reset_mid();
        test_div2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
